layer_output_serializer: RTL and testbench

- Sits between two fully connected layers.
- Captures the parallel `out`/`outvalid` results of all NUM_NEURONS neurons in layer N.
- Streams them one value per clock into the shared `myinput`/`myinputValid` bus of every layer N+1 neuron, neuron 0 first.
- Double-buffered, so layer N may produce its next result set while the current one is still being streamed.

---
 rtl/fnn_pkg.sv | 9 +
 rtl/layer_output_serializer_if.sv | 11 +
 rtl/neuron_capture_bank.sv | 48 ++++
 rtl/layer_output_serializer.sv | 122 ++++++++++++
 tb/tb_layer_output_serializer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fnn_pkg.sv
// Constants and types shared by the fully connected network datapath blocks.
package fnn_pkg;
  localparam int DATA_WIDTH     = 16;
  localparam int LAYER1_NEURONS = 30;
  localparam int LAYER2_NEURONS = 30;
  localparam int LAYER3_NEURONS = 10;

  typedef enum logic {IDLE, SHIFT} ser_state_t;
endpackage

// File: rtl/layer_output_serializer_if.sv
// Serial stream bus from the layer serializer into every next-layer neuron.
interface layer_output_serializer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] ser_data;
  logic                  ser_valid;
  logic                  ser_last;

  modport master (output ser_data, output ser_valid, output ser_last);
  modport slave  (input  ser_data, input  ser_valid, input  ser_last);
endinterface

// File: rtl/neuron_capture_bank.sv
// Collects per-neuron results until a full set is present; flags words that
// arrive for an already-filled slot or while the bank is frozen.
module neuron_capture_bank #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
  input  logic [NUM_NEURONS-1:0]            neuron_valid,
  input  logic                              freeze,
  input  logic                              clear,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] cap_merged,
  output logic                              complete,
  output logic                              overrun
);
  logic [NUM_NEURONS*DATA_WIDTH-1:0] cap_q;
  logic [NUM_NEURONS-1:0]            mask_q;
  logic [NUM_NEURONS-1:0]            accept;
  logic [NUM_NEURONS-1:0]            dropped;
  logic                              overrun_q;

  // cap_merged includes words accepted this cycle so a set completing now can be
  // handed over on the same edge.
  always_comb begin
    accept     = neuron_valid & ~mask_q & {NUM_NEURONS{~freeze}};
    dropped    = neuron_valid & ~accept;
    complete   = ~freeze & (&(mask_q | accept));
    cap_merged = cap_q;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (accept[i]) cap_merged[i*DATA_WIDTH +: DATA_WIDTH] = neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_q     <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      cap_q  <= cap_merged;
      mask_q <= clear ? '0 : (mask_q | accept);
      if (|dropped) overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
endmodule

// File: rtl/layer_output_serializer.sv
// Streams one captured result set per frame onto the shared next-layer input
// bus, neuron 0 first, reloading back-to-back when the next set is waiting.
//
// state | meaning
// IDLE  | no frame streaming, waiting for a complete set
// SHIFT | one beat per cycle; cnt is the index of the visible beat
module layer_output_serializer #(
  parameter int NUM_NEURONS = fnn_pkg::LAYER1_NEURONS,
  parameter int DATA_WIDTH  = fnn_pkg::DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
  input  logic [NUM_NEURONS-1:0]            neuron_valid,
  layer_output_serializer_if.master         ser,
  output logic                              busy,
  output logic                              overrun
);
  import fnn_pkg::*;

  localparam int CW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_NEURONS - 1);

  ser_state_t                        state_q, state_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] buf_q, buf_d, buf_shift;
  logic [DATA_WIDTH-1:0]             data_q, data_d;
  logic                              valid_q, valid_d;
  logic                              last_q, last_d;
  logic                              pending_q, pending_d;
  logic                              load;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] cap_merged;
  logic                              complete;

  neuron_capture_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_bank (
    .clk          (clk),
    .rst          (rst),
    .neuron_out   (neuron_out),
    .neuron_valid (neuron_valid),
    .freeze       (pending_q),
    .clear        (load),
    .cap_merged   (cap_merged),
    .complete     (complete),
    .overrun      (overrun)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    pending_d = pending_q;
    load      = 1'b0;
    buf_shift = buf_q >> DATA_WIDTH;
    case (state_q)
      IDLE: begin
        if (complete) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // A set completing in the last beat reloads on this same edge.
          if (pending_q || complete) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          buf_d  = buf_shift;
          data_d = buf_shift[DATA_WIDTH-1:0];
          last_d = (cnt_d == LAST);
          if (complete) pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      buf_d     = cap_merged;
      data_d    = cap_merged[DATA_WIDTH-1:0];
      valid_d   = 1'b1;
      last_d    = (LAST == '0);
      cnt_d     = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end

  assign ser.ser_data  = data_q;
  assign ser.ser_valid = valid_q;
  assign ser.ser_last  = last_q;
  assign busy          = (state_q == SHIFT) | pending_q;
endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench: a 4-neuron serializer for framing corner cases and a default
// 30-neuron one feeding a downstream valid counter.
module tb_layer_output_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] nv4_out = '0;
  logic [3:0]  nv4_valid = '0;
  logic [479:0] nv30_out = '0;
  logic [29:0] nv30_valid = '0;
  logic        busy4, ovr4, busy30, ovr30;
  int          n_checks = 0;
  int          n_fail = 0;
  int          pulses30 = 0;
  logic [15:0] exp8 [8];

  always #5 clk = ~clk;

  layer_output_serializer_if #(.DATA_WIDTH(16)) sif4 ();
  layer_output_serializer_if #(.DATA_WIDTH(16)) sif30 ();

  layer_output_serializer #(.NUM_NEURONS(4), .DATA_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .neuron_out(nv4_out), .neuron_valid(nv4_valid),
    .ser(sif4.master), .busy(busy4), .overrun(ovr4));

  layer_output_serializer dut30 (
    .clk(clk), .rst(rst), .neuron_out(nv30_out), .neuron_valid(nv30_valid),
    .ser(sif30.master), .busy(busy30), .overrun(ovr30));

  // Downstream neuron model: counts myinputValid pulses.
  always @(posedge clk) if (rst && sif30.ser_valid) pulses30 <= pulses30 + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set4(input logic [15:0] w0, input logic [15:0] w1,
                      input logic [15:0] w2, input logic [15:0] w3);
    nv4_out = {w3, w2, w1, w0};
  endtask

  task automatic beat4(input string tag, input logic [15:0] d, input logic last);
    check({tag, " valid"}, 32'(sif4.ser_valid), 32'd1);
    check({tag, " data"},  32'(sif4.ser_data),  32'(d));
    check({tag, " last"},  32'(sif4.ser_last),  32'(last));
    check({tag, " busy"},  32'(busy4),          32'd1);
  endtask

  task automatic idle4(input string tag);
    check({tag, " valid"}, 32'(sif4.ser_valid), 32'd0);
    check({tag, " busy"},  32'(busy4),          32'd0);
  endtask

  initial begin
    tick(); tick();
    check("rst data4",  32'(sif4.ser_data),  32'd0);
    check("rst valid4", 32'(sif4.ser_valid), 32'd0);
    check("rst last4",  32'(sif4.ser_last),  32'd0);
    check("rst busy4",  32'(busy4),          32'd0);
    check("rst ovr4",   32'(ovr4),           32'd0);
    check("rst valid30", 32'(sif30.ser_valid), 32'd0);
    check("rst busy30",  32'(busy30),          32'd0);
    rst = 1'b1;
    tick();

    // all valids in one cycle
    set4(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    nv4_valid = 4'hF;
    tick();
    nv4_valid = 4'h0;
    beat4("t1 b0", 16'h0011, 1'b0); tick();
    beat4("t1 b1", 16'h0022, 1'b0); tick();
    beat4("t1 b2", 16'h0033, 1'b0); tick();
    beat4("t1 b3", 16'h0044, 1'b1); tick();
    idle4("t1 end");
    tick();

    // staggered 3,0,2,1
    set4(16'hA000, 16'hA001, 16'hA002, 16'hA003);
    nv4_valid = 4'b1000; tick();
    nv4_valid = 4'b0001; tick();
    nv4_valid = 4'b0100; tick();
    idle4("t2 partial");
    nv4_valid = 4'b0010; tick();
    nv4_valid = 4'b0000;
    beat4("t2 b0", 16'hA000, 1'b0); tick();
    beat4("t2 b1", 16'hA001, 1'b0); tick();
    beat4("t2 b2", 16'hA002, 1'b0); tick();
    beat4("t2 b3", 16'hA003, 1'b1); tick();
    idle4("t2 end");

    // second set completes during beat 1 (pending) and during beat 3 (same-edge reload)
    for (int mode = 0; mode < 2; mode++) begin
      exp8 = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088};
      set4(16'h0011, 16'h0022, 16'h0033, 16'h0044);
      nv4_valid = 4'hF;
      tick();
      nv4_valid = 4'h0;
      for (int b = 0; b < 8; b++) begin
        beat4($sformatf("t3m%0d b%0d", mode, b), exp8[b], (b == 3) || (b == 7));
        if (b == (mode == 0 ? 1 : 3)) begin
          set4(16'h0055, 16'h0066, 16'h0077, 16'h0088);
          nv4_valid = 4'hF;
        end
        tick();
        nv4_valid = 4'h0;
      end
      idle4($sformatf("t3m%0d end", mode));
      check($sformatf("t3m%0d ovr", mode), 32'(ovr4), 32'd0);
    end

    // duplicate valid on neuron 2
    set4(16'h0000, 16'h0000, 16'h0100, 16'h0000);
    nv4_valid = 4'b0100; tick();
    set4(16'h0000, 16'h0000, 16'h0200, 16'h0000);
    nv4_valid = 4'b0100; tick();
    nv4_valid = 4'b0000;
    check("t4 ovr set", 32'(ovr4), 32'd1);
    check("t4 no start", 32'(sif4.ser_valid), 32'd0);
    set4(16'hB000, 16'hB001, 16'h0300, 16'hB003);
    nv4_valid = 4'b1011; tick();
    nv4_valid = 4'b0000;
    beat4("t4 b0", 16'hB000, 1'b0); tick();
    beat4("t4 b1", 16'hB001, 1'b0); tick();
    beat4("t4 b2", 16'h0100, 1'b0); tick();
    beat4("t4 b3", 16'hB003, 1'b1); tick();
    idle4("t4 end");
    check("t4 ovr sticky", 32'(ovr4), 32'd1);

    // reset during beat 1
    set4(16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03);
    nv4_valid = 4'hF; tick();
    nv4_valid = 4'h0;
    beat4("t5 b0", 16'h0C00, 1'b0); tick();
    beat4("t5 b1", 16'h0C01, 1'b0);
    rst = 1'b0; tick();
    idle4("t5 rst");
    check("t5 rst data", 32'(sif4.ser_data), 32'd0);
    check("t5 rst ovr",  32'(ovr4),          32'd0);
    rst = 1'b1; tick();
    idle4("t5 after");
    set4(16'h0D00, 16'h0D01, 16'h0D02, 16'h0D03);
    nv4_valid = 4'hF; tick();
    nv4_valid = 4'h0;
    beat4("t5 n0", 16'h0D00, 1'b0); tick();
    beat4("t5 n1", 16'h0D01, 1'b0); tick();
    beat4("t5 n2", 16'h0D02, 1'b0); tick();
    beat4("t5 n3", 16'h0D03, 1'b1); tick();
    idle4("t5 end");
    check("t5 ovr", 32'(ovr4), 32'd0);

    // 30-neuron frame
    for (int i = 0; i < 30; i++) nv30_out[i*16 +: 16] = 16'(i * 257);
    check("t6 pulses pre", 32'(pulses30), 32'd0);
    nv30_valid = '1; tick();
    nv30_valid = '0;
    for (int k = 0; k < 30; k++) begin
      check($sformatf("t6 b%0d valid", k), 32'(sif30.ser_valid), 32'd1);
      check($sformatf("t6 b%0d data", k),  32'(sif30.ser_data),  32'(k * 257));
      check($sformatf("t6 b%0d last", k),  32'(sif30.ser_last),  32'(k == 29));
      tick();
    end
    check("t6 end valid", 32'(sif30.ser_valid), 32'd0);
    check("t6 end busy",  32'(busy30),          32'd0);
    check("t6 pulses",    32'(pulses30),        32'd30);
    check("t6 ovr",       32'(ovr30),           32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
